// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation scheduler: zone states, display mode codes
// and the run-counter width helper.
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SPRK_DRIP  = 3'd1,
        ST_COMBO_DRIP = 3'd2,
        ST_DRIP       = 3'd3,
        ST_SPRINKLE   = 3'd4
    } zone_state_e;

    localparam logic [2:0] CODE_IDLE  = 3'b000;
    localparam logic [2:0] CODE_COMBO = 3'b001;
    localparam logic [2:0] CODE_DRIP  = 3'b010;
    localparam logic [2:0] CODE_SPRK  = 3'b100;

    function automatic int cnt_width(input int max_ticks);
        return $clog2(max_ticks + 1);
    endfunction

    // Both combo phases report the combo code so the display does not flicker at the switch.
    function automatic logic [2:0] code_of(input zone_state_e s);
        case (s)
            ST_SPRK_DRIP, ST_COMBO_DRIP: return CODE_COMBO;
            ST_DRIP:                     return CODE_DRIP;
            ST_SPRINKLE:                 return CODE_SPRK;
            default:                     return CODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/irrigation_zone_fsm.sv
// One irrigation zone: mode decode on start, latched mode while running,
// tick-driven run counter with combo phase switch and timeout.
module irrigation_zone_fsm
    import irrigation_pkg::*;
#(
    parameter int SPRINK_TICKS = 1350,
    parameter int MAX_TICKS    = 3600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       kill,
    input  logic       start_en,
    input  logic       t,
    input  logic       ua,
    input  logic       us,
    output logic       valve_sprk,
    output logic       valve_drip,
    output logic [2:0] code,
    output logic       run_done
);

    localparam int CW = cnt_width(MAX_TICKS);
    localparam logic [CW-1:0] LAST_TICK  = CW'(MAX_TICKS - 1);
    localparam logic [CW-1:0] SPRINK_END = CW'(SPRINK_TICKS);

    zone_state_e   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          done_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        if (state == ST_IDLE) begin
            cnt_nx = '0;
            if (start_en && !us) begin
                if (!ua)    state_nx = ST_SPRINKLE;
                else if (t) state_nx = ST_DRIP;
                else        state_nx = ST_SPRK_DRIP;
            end
        end else if (kill || us) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end else if (tick) begin
            // Timeout is taken as the counter would reach MAX_TICKS, so it never wraps.
            if (cnt >= LAST_TICK) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                done_nx  = 1'b1;
            end else begin
                cnt_nx = cnt + 1'b1;
                if (state == ST_SPRK_DRIP && cnt_nx == SPRINK_END)
                    state_nx = ST_COMBO_DRIP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            valve_sprk <= 1'b0;
            valve_drip <= 1'b0;
            code       <= CODE_IDLE;
            run_done   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            valve_sprk <= (state_nx == ST_SPRK_DRIP) || (state_nx == ST_SPRINKLE);
            valve_drip <= (state_nx == ST_COMBO_DRIP) || (state_nx == ST_DRIP);
            code       <= code_of(state_nx);
            run_done   <= done_nx;
        end
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// Multi-zone irrigation scheduler: registers the low-water fault and fans the
// global enable/override out to one FSM per zone.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int N_ZONES      = 4,
    parameter int SPRINK_TICKS = 1350,
    parameter int MAX_TICKS    = 3600
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 init,
    input  logic                 low_water,
    input  logic [N_ZONES-1:0]   T,
    input  logic [N_ZONES-1:0]   Ua,
    input  logic [N_ZONES-1:0]   Us,
    output logic [N_ZONES-1:0]   valve_sprk,
    output logic [N_ZONES-1:0]   valve_drip,
    output logic [3*N_ZONES-1:0] type_of_irrigation_state,
    output logic [N_ZONES-1:0]   run_done,
    output logic                 fault
);

    logic kill, start_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fault <= 1'b0;
        else       fault <= low_water;
    end

    // Starts are also blocked for the cycle after low_water drops, while fault is still set.
    assign kill     = low_water | ~init;
    assign start_en = init & ~low_water & ~fault;

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        irrigation_zone_fsm #(
            .SPRINK_TICKS (SPRINK_TICKS),
            .MAX_TICKS    (MAX_TICKS)
        ) u_zone (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .kill       (kill),
            .start_en   (start_en),
            .t          (T[i]),
            .ua         (Ua[i]),
            .us         (Us[i]),
            .valve_sprk (valve_sprk[i]),
            .valve_drip (valve_drip[i]),
            .code       (type_of_irrigation_state[3*i +: 3]),
            .run_done   (run_done[i])
        );
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: a zone-level reference model pushes
// the expected outputs for every clock edge, a monitor pops and compares them.
module tb_irrigation_scheduler;

    localparam int NZ  = 2;
    localparam int SPR = 4;
    localparam int MAX = 10;

    // Reference-model modes.
    localparam int M_IDLE = 0, M_COMBO = 1, M_DRIP = 2, M_SPRK = 3;

    typedef struct packed {
        logic [NZ-1:0]   sprk;
        logic [NZ-1:0]   drip;
        logic [3*NZ-1:0] code;
        logic [NZ-1:0]   done;
        logic            fault;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tick = 1'b0;
    logic            init = 1'b0;
    logic            low_water = 1'b0;
    logic [NZ-1:0]   t_s = '0, ua_s = '0, us_s = '0;
    logic [NZ-1:0]   valve_sprk, valve_drip, run_done;
    logic [3*NZ-1:0] code;
    logic            fault;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    int   m_mode[NZ];
    int   m_el[NZ];
    bit   m_done[NZ];
    bit   m_fault;

    irrigation_scheduler #(
        .N_ZONES      (NZ),
        .SPRINK_TICKS (SPR),
        .MAX_TICKS    (MAX)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .tick                     (tick),
        .init                     (init),
        .low_water                (low_water),
        .T                        (t_s),
        .Ua                       (ua_s),
        .Us                       (us_s),
        .valve_sprk               (valve_sprk),
        .valve_drip               (valve_drip),
        .type_of_irrigation_state (code),
        .run_done                 (run_done),
        .fault                    (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e = '0;
        for (int z = 0; z < NZ; z++) begin
            e.sprk[z] = (m_mode[z] == M_SPRK) || (m_mode[z] == M_COMBO && m_el[z] < SPR);
            e.drip[z] = (m_mode[z] == M_DRIP) || (m_mode[z] == M_COMBO && m_el[z] >= SPR);
            case (m_mode[z])
                M_COMBO: e.code[3*z +: 3] = 3'b001;
                M_DRIP:  e.code[3*z +: 3] = 3'b010;
                M_SPRK:  e.code[3*z +: 3] = 3'b100;
                default: e.code[3*z +: 3] = 3'b000;
            endcase
            e.done[z] = m_done[z];
        end
        e.fault = m_fault;
        return e;
    endfunction

    // Apply one cycle of inputs at the falling edge and predict the state after the next rising edge.
    task automatic drive(input bit r, input bit tk, input bit in, input bit lw,
                         input logic [NZ-1:0] tt, input logic [NZ-1:0] ua,
                         input logic [NZ-1:0] us);
        @(negedge clk);
        reset = r; tick = tk; init = in; low_water = lw;
        t_s = tt; ua_s = ua; us_s = us;
        for (int z = 0; z < NZ; z++) begin
            m_done[z] = 1'b0;
            if (r) begin
                m_mode[z] = M_IDLE;
                m_el[z]   = 0;
            end else if (m_mode[z] == M_IDLE) begin
                if (in && !lw && !m_fault && !us[z]) begin
                    m_el[z] = 0;
                    if (!ua[z])     m_mode[z] = M_SPRK;
                    else if (tt[z]) m_mode[z] = M_DRIP;
                    else            m_mode[z] = M_COMBO;
                end
            end else if (lw || !in || us[z]) begin
                m_mode[z] = M_IDLE;
                m_el[z]   = 0;
            end else if (tk) begin
                m_el[z]++;
                if (m_el[z] >= MAX) begin
                    m_mode[z] = M_IDLE;
                    m_el[z]   = 0;
                    m_done[z] = 1'b1;
                end
            end
        end
        m_fault = r ? 1'b0 : lw;
        exp_q.push_back(model_outputs());
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valve_sprk", 8'(valve_sprk), 8'(e.sprk));
            chk("valve_drip", 8'(valve_drip), 8'(e.drip));
            chk("code", 8'(code), 8'(e.code));
            chk("run_done", 8'(run_done), 8'(e.done));
            chk("fault", 8'(fault), 8'(e.fault));
            chk("valve_excl", 8'(valve_sprk & valve_drip), 8'h00);
        end
    end

    initial begin
        for (int z = 0; z < NZ; z++) begin
            m_mode[z] = M_IDLE; m_el[z] = 0; m_done[z] = 1'b0;
        end
        m_fault = 1'b0;

        #1;
        chk("rst_sprk", 8'(valve_sprk), 8'h00);
        chk("rst_drip", 8'(valve_drip), 8'h00);
        chk("rst_code", 8'(code), 8'h00);
        chk("rst_done", 8'(run_done), 8'h00);
        chk("rst_fault", 8'(fault), 8'h00);
        drive(1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drive(1, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        // Zone0 combo through timeout, zone1 held idle by wet soil.
        drive(0, 0, 1, 0, 2'b00, 2'b01, 2'b10);
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 1, 0, 2'b00, 2'b01, 2'b10);
            drive(0, 0, 1, 0, 2'b00, 2'b01, 2'b10);
        end
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        // Zone1 drip, wet soil at the 6th tick; zone0 stays idle.
        drive(0, 0, 1, 0, 2'b10, 2'b10, 2'b01);
        for (int k = 0; k < 5; k++) drive(0, 1, 1, 0, 2'b10, 2'b10, 2'b01);
        drive(0, 1, 1, 0, 2'b10, 2'b10, 2'b11);
        drive(0, 0, 1, 0, 2'b10, 2'b10, 2'b11);

        // Both sprinkle, then low water holds everything off.
        drive(0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        drive(0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) drive(0, k[0], 1, 1, 2'b00, 2'b00, 2'b00);
        drive(0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        drive(0, 0, 1, 0, 2'b00, 2'b00, 2'b00);

        // Zone0 wet soil with init: never opens.
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 2'b00, 2'b01, 2'b11);

        // Combo interrupted by an asynchronous reset after the 5th tick, then restarted.
        drive(0, 0, 1, 0, 2'b00, 2'b01, 2'b10);
        for (int k = 0; k < 5; k++) drive(0, 1, 1, 0, 2'b00, 2'b01, 2'b10);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_sprk", 8'(valve_sprk), 8'h00);
        chk("async_rst_drip", 8'(valve_drip), 8'h00);
        chk("async_rst_code", 8'(code), 8'h00);
        drive(1, 0, 1, 0, 2'b00, 2'b01, 2'b10);
        drive(0, 0, 1, 0, 2'b00, 2'b01, 2'b10);
        for (int k = 0; k < 5; k++) drive(0, 1, 1, 0, 2'b00, 2'b01, 2'b10);
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        // Zone1 wet soil coincides with the timeout tick.
        drive(0, 0, 1, 0, 2'b10, 2'b10, 2'b01);
        for (int k = 0; k < 9; k++) drive(0, 1, 1, 0, 2'b10, 2'b10, 2'b01);
        drive(0, 1, 1, 0, 2'b10, 2'b10, 2'b11);
        drive(0, 0, 1, 0, 2'b10, 2'b10, 2'b11);

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [NZ-1:0] wet;
            for (int z = 0; z < NZ; z++) wet[z] = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 199) == 0, 1'($urandom), $urandom_range(0, 31) != 0,
                  $urandom_range(0, 31) == 0, NZ'($urandom), NZ'($urandom), wet);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
